sram_arbiter: RTL
=================

# sram_arbiter

Arbiter and sequencer for the single 8-bit asynchronous SRAM (21-bit address, 2 MB) shared by the video fetch engine and the CPU bus interface. It sits between the system core and the SRAM pins. It grants video fixed-length read bursts with priority and CPU single-byte reads or writes with a guaranteed slot. It generates all SRAM address, write-enable and data-direction timing.

## Interface
Parameters:
- VGA_BURST, default 8: bytes per video burst, range 1..64.

Ports:
- clk  in  1  system clock (the SRAM clock domain); all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- vga_req  in  1  video burst request; held until vga_ack.
- vga_addr  in  21  burst start address; sampled at grant.
- vga_ack  out  1  one-cycle pulse, burst accepted.
- vga_rvalid  out  1  one-cycle pulse per returned byte.
- vga_rdata  out  8  returned byte, valid with vga_rvalid.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  21  access address; sampled at grant.
- cpu_wdata  in  8  write data; sampled at grant.
- cpu_ack  out  1  one-cycle pulse, access accepted.
- cpu_rvalid  out  1  one-cycle pulse, read data valid.
- cpu_rdata  out  8  read data; holds its value until the next CPU read.
- sram_addr  out  21  SRAM address, registered.
- sram_we_n  out  1  SRAM write enable, active low, registered.
- sram_dq_o  out  8  SRAM write data.
- sram_dq_oe  out  1  data bus output enable; the top level builds the tristate.
- sram_dq_i  in  8  SRAM read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: arbitration.
  - VRD: video burst.
  - CRD: CPU read.
  - CWS, CWP, CWH: CPU write setup, pulse, hold.
- Arbitration, evaluated only in IDLE:
  - Only vga_req: grant video.
  - Only cpu_req: grant CPU.
  - Both: grant CPU if last_grant == VIDEO, else grant video.
  - last_grant is updated on every grant and resets to CPU, so video wins the first tie.
- Grant edge:
  - Capture the requester's address (and CPU we/wdata).
  - Load sram_addr.
  - Pulse the matching ack in the next cycle.
  - Enter VRD, CRD or CWS.
- VRD:
  - Runs VGA_BURST cycles.
  - Cycle k drives sram_addr = start+k.
  - sram_dq_i is sampled at the edge ending cycle k.
  - vga_rvalid/vga_rdata are presented in the following cycle.
  - A 6-bit counter ends the burst; return to IDLE.
  - Address increment is modulo 2^21: 0x1FFFFF wraps to 0x000000 within a burst.
- CRD: one cycle. Address is driven, data is sampled at the edge ending CRD, cpu_rvalid is asserted in the next cycle, then IDLE.
- CPU write sequence:
  - CWS: addr and data driven, sram_dq_oe=1, sram_we_n=1.
  - CWP: sram_we_n=0.
  - CWH: sram_we_n=1, addr/data/oe held.
  - Then IDLE, where sram_dq_oe=0.
- sram_addr, sram_dq_o and sram_we_n change only on state edges and never glitch within a cycle. Address and data are stable one cycle either side of the WE pulse.
- sram_dq_oe is 0 in IDLE, VRD and CRD, which provides a bus turnaround cycle after every write.
- Requests arriving outside IDLE wait. A request dropped before ack is simply not served.

## Timing
- Reset values:
  - State IDLE, last_grant CPU.
  - sram_addr=0, sram_we_n=1, sram_dq_oe=0, sram_dq_o=0.
  - All acks and rvalids 0, vga_rdata=0, cpu_rdata=0, busy=0.
- Reset asserted mid-operation immediately forces sram_we_n=1 and sram_dq_oe=0 (asynchronous). The in-flight access is dropped: no further rvalid or ack is issued for it.
- Grant latency from req high in IDLE: ack in the next cycle.
- Video: first vga_rvalid 2 cycles after the grant edge. Bytes are back-to-back, VGA_BURST consecutive cycles.
- CPU read: cpu_rvalid 2 cycles after the grant edge.
- CPU write: 3 busy cycles, then one IDLE cycle.
- Cycle cost per access includes one IDLE arbitration cycle:
  - video burst: VGA_BURST+1 cycles.
  - CPU read: 2 cycles.
  - CPU write: 4 cycles.
- Worst-case video wait with both requesters saturating: 4 cycles (one CPU write).
- Worst-case CPU wait: VGA_BURST+1 cycles.
- rvalid from a finishing access and ack of the next grant may coincide. They are independent outputs.

## Test plan
- Reset, then vga_req with vga_addr=0x00100 and SRAM model memory = address LSBs, VGA_BURST=8 -> vga_ack 1 cycle after grant edge; 8 consecutive vga_rvalid with data 0x00..0x07; busy high for 8 cycles.
- CPU write 0xA5 to 0x1ABCDE, then CPU read of the same address -> sram_we_n low exactly 1 cycle, addr/data stable in CWS..CWH, sram_dq_oe low in the following IDLE; read returns cpu_rdata=0xA5 with cpu_rvalid 2 cycles after its grant.
- vga_req and cpu_req held continuously -> grants alternate V,C,V,C starting with video; no CPU wait exceeds 9 cycles and no video wait exceeds 4 cycles.
- Burst at vga_addr=0x1FFFFD, VGA_BURST=8 -> sram_addr sequence 0x1FFFFD,0x1FFFFE,0x1FFFFF,0x000000..0x000004.
- Assert reset during CWP -> sram_we_n=1 and sram_dq_oe=0 before the next clock edge; no cpu_ack or cpu_rvalid for the aborted access; after release, a fresh cpu_req is served normally.
- cpu_req pulsed for one cycle while a video burst is in progress -> no cpu_ack and no SRAM write occurs.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Request/response buses for the video and CPU clients plus the SRAM pin bundle
// shared with sram_arbiter.
interface sram_arbiter_if;
  logic        vga_req;
  logic [20:0] vga_addr;
  logic        vga_ack;
  logic        vga_rvalid;
  logic [7:0]  vga_rdata;

  logic        cpu_req;
  logic        cpu_we;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;

  logic [20:0] sram_addr;
  logic        sram_we_n;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_i;
  logic        busy;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_dq_i,
    output vga_ack, vga_rvalid, vga_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           sram_addr, sram_we_n, sram_dq_o, sram_dq_oe, busy
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_dq_i,
    input  vga_ack, vga_rvalid, vga_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           sram_addr, sram_we_n, sram_dq_o, sram_dq_oe, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Arbiter and access sequencer for one 8-bit asynchronous SRAM shared by the
// video fetch engine (fixed bursts, priority) and the CPU (single bytes).
module sram_arbiter #(
  parameter int VGA_BURST = 8
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, VRD, CRD, CWS, CWP, CWH} state_t;
  typedef enum logic {LAST_CPU, LAST_VIDEO} last_t;

  localparam logic [5:0] LAST_BEAT = 6'(VGA_BURST - 1);

  state_t     state;
  state_t     state_nxt;
  last_t      last_grant;
  logic       grant_vga;
  logic       grant_cpu;
  logic [5:0] beat;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt = state;
    grant_vga = 1'b0;
    grant_cpu = 1'b0;
    case (state)
      IDLE: begin
        // A tie goes to whichever client was not served last.
        if (bus.vga_req && (!bus.cpu_req || last_grant == LAST_CPU)) begin
          grant_vga = 1'b1;
          state_nxt = VRD;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
          state_nxt = bus.cpu_we ? CWS : CRD;
        end
      end
      VRD:     if (beat == LAST_BEAT) state_nxt = IDLE;
      CRD:     state_nxt = IDLE;
      CWS:     state_nxt = CWP;
      CWP:     state_nxt = CWH;
      CWH:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant     <= LAST_CPU;
      beat           <= '0;
      bus.sram_addr  <= '0;
      bus.sram_we_n  <= 1'b1;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_dq_o  <= '0;
      bus.vga_ack    <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      bus.vga_rvalid <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.vga_rdata  <= '0;
      bus.cpu_rdata  <= '0;
    end else begin
      bus.vga_ack    <= grant_vga;
      bus.cpu_ack    <= grant_cpu;
      bus.vga_rvalid <= (state == VRD);
      bus.cpu_rvalid <= (state == CRD);
      if (state == VRD) bus.vga_rdata <= bus.sram_dq_i;
      if (state == CRD) bus.cpu_rdata <= bus.sram_dq_i;

      if (grant_vga) begin
        last_grant    <= LAST_VIDEO;
        bus.sram_addr <= bus.vga_addr;
        beat          <= '0;
      end else if (grant_cpu) begin
        last_grant    <= LAST_CPU;
        bus.sram_addr <= bus.cpu_addr;
        if (bus.cpu_we) bus.sram_dq_o <= bus.cpu_wdata;
      end else if (state == VRD && beat != LAST_BEAT) begin
        // 21-bit add wraps 0x1FFFFF to 0 inside a burst.
        bus.sram_addr <= bus.sram_addr + 21'd1;
        beat          <= beat + 6'd1;
      end

      // Pin controls are decoded from the upcoming state so they are glitch-free registers.
      bus.sram_we_n  <= (state_nxt != CWP);
      bus.sram_dq_oe <= (state_nxt inside {CWS, CWP, CWH});
    end
  end

  assign bus.busy = (state != IDLE);
endmodule
